serial_loader: RTL and testbench
================================

SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits; legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first received data bit lands in bit WIDTH-1; 0 = first bit lands in bit 0.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1: frame start request, sampled when ser_valid=0 or ser_valid=1.
REQ-006 SHALL have port ser_valid  input  1: ser_in carries a valid bit this cycle.
REQ-007 SHALL have port ser_in  input  1: serial data/parity bit.
REQ-008 SHALL have port busy  output  1: high while a frame is in progress.
REQ-009 SHALL have port wr_en  output  1: one-cycle pulse; data is a valid word, intended for a downstream register's write enable.
REQ-010 SHALL have port data  output  WIDTH: assembled word; drives the downstream register's data input.
REQ-011 SHALL have port parity_err  output  1: one-cycle pulse; frame rejected on parity mismatch.

Function
REQ-012 SHALL implement states IDLE, RECV, PARITY and DONE.
REQ-013 IDLE: start=1 -> RECV; bit counter cleared; shift register cleared; busy=1 from the next cycle.
REQ-014 IDLE: ser_valid bits with start=0 SHALL be ignored.
REQ-015 RECV: each cycle with ser_valid=1 SHALL shift ser_in into the shift register per MSB_FIRST and increment the bit counter.
REQ-016 RECV: after the WIDTH-th valid bit is accepted, the FSM SHALL move to PARITY; cycles with ser_valid=0 hold all state (no timeout).
REQ-017 PARITY: the next ser_valid=1 bit SHALL be taken as an even-parity bit (XOR of WIDTH data bits and the parity bit must be 0) -> DONE.
REQ-018 DONE, parity good: wr_en=1 and data=assembled word for exactly one cycle; parity_err=0.
REQ-019 DONE, parity bad: parity_err=1 for exactly one cycle; wr_en=0; data SHALL keep its previous value.
REQ-020 DONE SHALL last exactly one cycle, then IDLE; busy=0 in DONE.
REQ-021 Latency: wr_en SHALL assert on the cycle after the parity bit is sampled.
REQ-022 data SHALL change only in the DONE cycle of a good frame; it holds between frames, so the downstream register may sample on wr_en only.
REQ-023 start asserted in RECV or PARITY SHALL be ignored; it does not restart the frame.
REQ-024 start asserted in the DONE cycle SHALL be ignored; a new frame requires start in IDLE.
REQ-025 start and ser_valid=1 together in IDLE: that ser_in bit SHALL NOT be captured; the first data bit is the next valid bit.
REQ-026 The bit counter SHALL be $clog2(WIDTH+1) bits wide and never wrap within a frame.
REQ-027 wr_en and parity_err SHALL never be high in the same cycle.

Reset
REQ-028 rst=0 SHALL force state=IDLE, busy=0, wr_en=0, parity_err=0, data='0, shift register and counter=0, asynchronously.
REQ-029 Reset mid-frame SHALL discard the partial word; no wr_en or parity_err pulse SHALL follow.
REQ-030 After rst deasserts, the first start is honoured on the first rising edge with rst=1.

Verification
REQ-031 WIDTH=8, MSB_FIRST=1: start, then bits 1,0,1,0,0,1,0,1 and parity 0 -> one wr_en pulse, data=8'hA5, parity_err=0.
REQ-032 Same frame with parity 1 -> parity_err pulse, no wr_en, data keeps its prior value (8'hA5 from the previous frame).
REQ-033 MSB_FIRST=0: bits 1,0,0,0,0,0,0,0 and parity 1 -> data=8'h01 with wr_en.
REQ-034 Gapped stream: 0-3 idle cycles with ser_valid=0 inserted randomly between bits -> same data; a second start mid-frame is ignored.
REQ-035 Assert rst after 4 bits, release, then send a full frame 8'h3C with parity 0 -> exactly one wr_en with data=8'h3C; no pulse is caused by the aborted frame.
REQ-036 Back-to-back frames 8'h01, 8'hFF (parity 1, 0), with start in the cycle after DONE -> two wr_en pulses carrying the correct data.

Source files
------------

// File: rtl/serial_loader.sv
// Serial-to-parallel frame loader: WIDTH data bits plus one even-parity bit
// per frame, producing a one-cycle write strobe for a downstream register.
module serial_loader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_valid,
    input  logic             ser_in,
    output logic             busy,
    output logic             wr_en,
    output logic [WIDTH-1:0] data,
    output logic             parity_err,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             perr_q, perr_d;
    logic [WIDTH-1:0] shifted;
    logic             par_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
        end
    end

    // Even parity over data and parity bit; a nonzero XOR rejects the frame.
    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], ser_in};
        end else begin
            shifted = {ser_in, shreg_q[WIDTH-1:1]};
        end
        par_bad = (^shreg_q) ^ ser_in;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_d   = '0;
                    shreg_d = '0;
                end
            end
            RECV: begin
                if (ser_valid) begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (ser_valid) begin
                    perr_d  = par_bad;
                    state_d = DONE;
                    if (!par_bad) begin
                        data_d = shreg_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy       = (state_q == RECV) || (state_q == PARITY);
        wr_en      = (state_q == DONE) && !perr_q;
        parity_err = (state_q == DONE) && perr_q;
        data       = data_q;
        state_dbg  = state_q;
    end

endmodule

// File: tb/tb_serial_loader.sv
// Bench for serial_loader: an MSB-first and an LSB-first instance share one
// serial stream; a frame-level model predicts pulses, data and busy.
module tb_serial_loader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic ser_valid = 1'b0;
    logic ser_in = 1'b0;

    logic       busy_m, wr_en_m, perr_m;
    logic [7:0] data_m;
    logic [1:0] state_m;
    logic       busy_l, wr_en_l, perr_l;
    logic [7:0] data_l;
    logic [1:0] state_l;

    int n_pass = 0;
    int n_total = 0;

    // Pending DONE-cycle outcomes, pushed by the driver when the parity bit goes in.
    logic [7:0] exp_q[$];
    logic [7:0] exp_l_q[$];
    logic       exp_good_q[$];
    logic       mdl_busy = 1'b0;
    logic [7:0] mdl_m = 8'h00;
    logic [7:0] mdl_l = 8'h00;

    serial_loader #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_in(ser_in),
        .busy(busy_m), .wr_en(wr_en_m), .data(data_m), .parity_err(perr_m),
        .state_dbg(state_m)
    );

    serial_loader #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_in(ser_in),
        .busy(busy_l), .wr_en(wr_en_l), .data(data_l), .parity_err(perr_l),
        .state_dbg(state_l)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    // Word seen by an LSB-first receiver when bits are sent seq[7] first.
    function automatic logic [7:0] rev8(input logic [7:0] w);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = w[7-i];
        return r;
    endfunction

    task automatic drive(input logic s, input logic v, input logic d);
        start = s;
        ser_valid = v;
        ser_in = d;
        @(posedge clk);
        #1;
    endtask

    // Start cycle, 8 data bits (seq[7] first), parity bit; returns in the DONE cycle.
    task automatic send_frame(input logic [7:0] seq, input logic p, input int gapmax,
                              input bit mid_start, input bit start_with_valid);
        int g;
        logic good;
        drive(1'b1, start_with_valid, 1'b1);
        mdl_busy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
            repeat (g) drive(mid_start, 1'b0, 1'($urandom_range(0, 1)));
            drive(mid_start, 1'b1, (i < 8) ? seq[7-i] : p);
        end
        good = (($countones(seq) + int'(p)) % 2) == 0;
        exp_q.push_back(seq);
        exp_l_q.push_back(rev8(seq));
        exp_good_q.push_back(good);
        mdl_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [7:0] w, wl;
        logic g;
        if (!rst) begin
            chk("rst_busy", {30'd0, busy_m, busy_l}, 32'd0);
            chk("rst_pulses", {28'd0, wr_en_m, perr_m, wr_en_l, perr_l}, 32'd0);
            chk("rst_data_m", {24'd0, data_m}, 32'd0);
            chk("rst_data_l", {24'd0, data_l}, 32'd0);
            mdl_m = 8'h00;
            mdl_l = 8'h00;
        end else begin
            chk("busy_m", {31'd0, busy_m}, {31'd0, mdl_busy});
            chk("busy_l", {31'd0, busy_l}, {31'd0, mdl_busy});
            chk("excl_m", {31'd0, wr_en_m & perr_m}, 32'd0);
            chk("excl_l", {31'd0, wr_en_l & perr_l}, 32'd0);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                wl = exp_l_q.pop_front();
                g = exp_good_q.pop_front();
                chk("wr_en_m", {31'd0, wr_en_m}, {31'd0, g});
                chk("perr_m", {31'd0, perr_m}, {31'd0, !g});
                chk("wr_en_l", {31'd0, wr_en_l}, {31'd0, g});
                chk("perr_l", {31'd0, perr_l}, {31'd0, !g});
                if (g) begin
                    mdl_m = w;
                    mdl_l = wl;
                end
            end else begin
                chk("idle_pulse_m", {30'd0, wr_en_m, perr_m}, 32'd0);
                chk("idle_pulse_l", {30'd0, wr_en_l, perr_l}, 32'd0);
            end
            chk("data_m", {24'd0, data_m}, {24'd0, mdl_m});
            chk("data_l", {24'd0, data_l}, {24'd0, mdl_l});
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("lit_reset_state", {30'd0, state_m}, 32'd0);
        chk("lit_reset_data", {24'd0, data_m}, 32'd0);
        rst = 1'b1;

        // Valid bits without start in IDLE are ignored.
        repeat (4) drive(1'b0, 1'b1, 1'($urandom_range(0, 1)));

        send_frame(8'hA5, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_a5_state", {30'd0, state_m}, 32'd3);
        chk("lit_a5_data", {24'd0, data_m}, 32'hA5);
        chk("lit_a5_wr_en", {30'd0, wr_en_m, perr_m}, 32'd2);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);

        send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_bad_par", {30'd0, wr_en_m, perr_m}, 32'd1);
        chk("lit_bad_hold", {24'd0, data_m}, 32'hA5);
        drive(1'b0, 1'b0, 1'b0);

        send_frame(8'h80, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_lsb_data", {24'd0, data_l}, 32'h01);
        chk("lit_lsb_wr_en", {31'd0, wr_en_l}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Gapped streams with start held high mid-frame and start+valid together.
        send_frame(8'hC3, 1'b0, 3, 1'b1, 1'b1);
        chk("lit_gap_c3", {24'd0, data_m}, 32'hC3);
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 3, 1'b1, 1'b0);
        chk("lit_gap_a5", {24'd0, data_m}, 32'hA5);
        drive(1'b0, 1'b0, 1'b0);

        // Abort a frame after 4 bits with reset.
        drive(1'b1, 1'b0, 1'b0);
        mdl_busy = 1'b1;
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        mdl_busy = 1'b0;
        #1;
        chk("lit_abort_data", {24'd0, data_m}, 32'd0);
        chk("lit_abort_busy", {31'd0, busy_m}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(8'h3C, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_3c_data", {24'd0, data_m}, 32'h3C);
        chk("lit_3c_wr_en", {31'd0, wr_en_m}, 32'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Back-to-back, with a start in DONE that must be ignored.
        send_frame(8'h01, 1'b1, 0, 1'b0, 1'b0);
        chk("lit_b2b_01", {24'd0, data_m}, 32'h01);
        drive(1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 0, 1'b0, 1'b0);
        chk("lit_b2b_ff", {24'd0, data_m}, 32'hFF);

        repeat (4) drive(1'b0, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
